// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and constants for the coin vending controller:
//               FSM state encodings, hopper coin_sel codes, coin values and
//               small helpers for change-coin selection.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_VEND    = 3'd2,
    ST_CHANGE  = 3'd3,
    ST_HOLD    = 3'd4
  } vend_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;
  localparam logic [1:0] COIN_200  = 2'b11;

  localparam logic [7:0] VAL_50  = 8'd50;
  localparam logic [7:0] VAL_100 = 8'd100;
  localparam logic [7:0] VAL_200 = 8'd200;

  // Largest coin that still fits in the outstanding amount.
  function automatic logic [1:0] greedy_sel(input logic [11:0] amount);
    logic [1:0] sel;
    if (amount >= 12'd200)      sel = COIN_200;
    else if (amount >= 12'd100) sel = COIN_100;
    else                        sel = COIN_50;
    return sel;
  endfunction

  function automatic logic [7:0] sel_value(input logic [1:0] sel);
    logic [7:0] val;
    case (sel)
      COIN_50:  val = VAL_50;
      COIN_100: val = VAL_100;
      COIN_200: val = VAL_200;
      default:  val = 8'd0;
    endcase
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_edge_arb.sv
`default_nettype none
// ============================================================================
// Module      : coin_edge_arb
// Description : Coin-button front end. Rising-edge detects the three coin
//               levels, latches them into one pending bit per denomination
//               and serves at most one pending coin per cycle with fixed
//               priority 50 > 100 > 200. Produces a registered reject pulse
//               for coins that cannot be accepted.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               r50/r100/r200     - synchronised coin button levels
//               accept_en         - controller is in IDLE or COLLECT
//               flush             - drop all pending coins (vend starting)
//               serve_valid       - a coin is credited this cycle
//               serve_value[7:0]  - value in cents of the served coin
//               reject            - 1-cycle pulse, a coin was refused
// Revision    : 1.0 - initial release
// ============================================================================
module coin_edge_arb
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       r50,
  input  logic       r100,
  input  logic       r200,
  input  logic       accept_en,
  input  logic       flush,
  output logic       serve_valid,
  output logic [7:0] serve_value,
  output logic       reject
);

  logic [2:0] r_prev;
  logic [2:0] r_pend;
  logic       r_reject;

  logic [2:0] w_level;
  logic [2:0] w_edge;
  logic [2:0] w_serve_mask;
  logic [2:0] w_pend_next;
  logic       w_reject;

  // Bit order everywhere: [0]=50, [1]=100, [2]=200.
  assign w_level = {r200, r100, r50};
  assign w_edge  = w_level & ~r_prev;

  always_comb begin
    w_serve_mask = 3'b000;
    if (accept_en && !flush) begin
      if (r_pend[0])      w_serve_mask = 3'b001;
      else if (r_pend[1]) w_serve_mask = 3'b010;
      else if (r_pend[2]) w_serve_mask = 3'b100;
    end
  end

  always_comb begin
    serve_value = 8'd0;
    if (w_serve_mask[0])      serve_value = VAL_50;
    else if (w_serve_mask[1]) serve_value = VAL_100;
    else if (w_serve_mask[2]) serve_value = VAL_200;
  end

  assign serve_valid = |w_serve_mask;

  always_comb begin
    w_pend_next = r_pend;
    w_reject    = 1'b0;
    if (!accept_en) begin
      // Machine busy: every new coin is refused and nothing is latched.
      w_pend_next = 3'b000;
      w_reject    = |w_edge;
    end else if (flush) begin
      // Credit already covers the price: leftovers and same-cycle inserts
      // are refused together as a single pulse.
      w_pend_next = 3'b000;
      w_reject    = (|r_pend) | (|w_edge);
    end else begin
      // An edge on a denomination that is still pending is refused; the
      // existing pending coin is still served normally.
      w_pend_next = (r_pend & ~w_serve_mask) | (w_edge & ~r_pend);
      w_reject    = |(w_edge & r_pend);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev   <= 3'b000;
      r_pend   <= 3'b000;
      r_reject <= 1'b0;
    end else begin
      r_prev   <= w_level;
      r_pend   <= w_pend_next;
      r_reject <= w_reject;
    end
  end

  assign reject = r_reject;

endmodule
`default_nettype wire

// File: rtl/coin_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : coin_vend_ctrl
// Description : Vending controller in front of the coffee datapath. Collects
//               coins into a credit register, requests a cup once credit
//               reaches PRICE, then pays back change one coin at a time via
//               the hopper handshake. Cancel and inactivity timeout refund
//               the credit; a hold period follows every vend or refund.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               r50/r100/r200      - coin button levels
//               cancel             - refund request (rising edge)
//               cafe_ack/cafe_req  - cup dispenser handshake
//               coin_ack/coin_req  - hopper handshake, coin_sel picks coin
//               reject             - 1-cycle pulse for a refused coin
//               credit_o, state_o  - current credit and FSM state
//               busy               - VEND, CHANGE or HOLD
// Revision    : 1.0 - initial release
// ============================================================================
module coin_vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned PRICE          = 250,
  parameter int unsigned HOLD_CYCLES    = CLK_FREQ * 4,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ * 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r50,
  input  logic        r100,
  input  logic        r200,
  input  logic        cancel,
  input  logic        cafe_ack,
  input  logic        coin_ack,
  output logic        cafe_req,
  output logic        coin_req,
  output logic [1:0]  coin_sel,
  output logic        reject,
  output logic [11:0] credit_o,
  output logic [2:0]  state_o,
  output logic        busy
);

  localparam logic [11:0] C_PRICE       = 12'(PRICE);
  localparam logic [31:0] C_TIMEOUT_END = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] C_HOLD_END    = 32'(HOLD_CYCLES - 1);

  vend_state_t r_state;
  vend_state_t w_state_next;
  logic [11:0] r_credit,   w_credit_next;
  logic [11:0] r_change,   w_change_next;
  logic [31:0] r_timer,    w_timer_next;
  logic [31:0] r_hold_cnt, w_hold_cnt_next;
  logic        r_cafe_req, w_cafe_req_next;
  logic        r_coin_req, w_coin_req_next;
  logic [1:0]  r_coin_sel, w_coin_sel_next;
  logic        r_cancel_prev;

  logic        w_accept_en;
  logic        w_flush;
  logic        w_serve_valid;
  logic [7:0]  w_serve_value;
  logic [11:0] w_serve_add;
  logic        w_cancel_edge;

  assign w_accept_en   = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign w_flush       = (r_state == ST_COLLECT) && (r_credit >= C_PRICE);
  assign w_cancel_edge = cancel & ~r_cancel_prev;
  assign w_serve_add   = w_serve_valid ? {4'd0, w_serve_value} : 12'd0;

  coin_edge_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .r50         (r50),
    .r100        (r100),
    .r200        (r200),
    .accept_en   (w_accept_en),
    .flush       (w_flush),
    .serve_valid (w_serve_valid),
    .serve_value (w_serve_value),
    .reject      (reject)
  );

  always_comb begin
    w_state_next    = r_state;
    w_credit_next   = r_credit;
    w_change_next   = r_change;
    w_timer_next    = r_timer;
    w_hold_cnt_next = r_hold_cnt;
    w_cafe_req_next = r_cafe_req;
    w_coin_req_next = r_coin_req;
    w_coin_sel_next = r_coin_sel;

    case (r_state)
      ST_IDLE: begin
        // Credit is always zero here, so cancel has nothing to refund.
        w_timer_next = 32'd0;
        if (w_serve_valid) begin
          w_credit_next = r_credit + w_serve_add;
          w_state_next  = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (r_credit >= C_PRICE) begin
          // Request goes out registered so it is high on the first VEND cycle.
          w_state_next    = ST_VEND;
          w_cafe_req_next = 1'b1;
          w_timer_next    = 32'd0;
        end else if (w_cancel_edge || (r_timer == C_TIMEOUT_END)) begin
          // A coin served in this same cycle is consumed by the arbiter,
          // so it is folded into the refund rather than lost.
          w_state_next  = ST_CHANGE;
          w_change_next = r_credit + w_serve_add;
          w_credit_next = 12'd0;
          w_timer_next  = 32'd0;
        end else if (w_serve_valid) begin
          w_credit_next = r_credit + w_serve_add;
          w_timer_next  = 32'd0;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end

      ST_VEND: begin
        if (cafe_ack) begin
          w_cafe_req_next = 1'b0;
          w_change_next   = r_credit - C_PRICE;
          w_credit_next   = 12'd0;
          w_state_next    = (r_credit != C_PRICE) ? ST_CHANGE : ST_HOLD;
        end
      end

      ST_CHANGE: begin
        if (r_coin_req) begin
          if (coin_ack) begin
            w_coin_req_next = 1'b0;
            w_coin_sel_next = COIN_NONE;
            w_change_next   = r_change - {4'd0, sel_value(r_coin_sel)};
          end
        end else if (r_change == 12'd0) begin
          w_state_next    = ST_HOLD;
          w_hold_cnt_next = 32'd0;
        end else begin
          // Reaching here always costs one low cycle after the previous ack,
          // which gives the hopper its mandatory request gap.
          w_coin_req_next = 1'b1;
          w_coin_sel_next = greedy_sel(r_change);
        end
      end

      ST_HOLD: begin
        if (r_hold_cnt == C_HOLD_END) begin
          w_state_next    = ST_IDLE;
          w_hold_cnt_next = 32'd0;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 32'd1;
        end
      end

      default: begin
        w_state_next    = ST_IDLE;
        w_credit_next   = 12'd0;
        w_change_next   = 12'd0;
        w_timer_next    = 32'd0;
        w_hold_cnt_next = 32'd0;
        w_cafe_req_next = 1'b0;
        w_coin_req_next = 1'b0;
        w_coin_sel_next = COIN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_credit      <= 12'd0;
      r_change      <= 12'd0;
      r_timer       <= 32'd0;
      r_hold_cnt    <= 32'd0;
      r_cafe_req    <= 1'b0;
      r_coin_req    <= 1'b0;
      r_coin_sel    <= COIN_NONE;
      r_cancel_prev <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_credit      <= w_credit_next;
      r_change      <= w_change_next;
      r_timer       <= w_timer_next;
      r_hold_cnt    <= w_hold_cnt_next;
      r_cafe_req    <= w_cafe_req_next;
      r_coin_req    <= w_coin_req_next;
      r_coin_sel    <= w_coin_sel_next;
      r_cancel_prev <= cancel;
    end
  end

  assign cafe_req = r_cafe_req;
  assign coin_req = r_coin_req;
  assign coin_sel = r_coin_sel;
  assign credit_o = r_credit;
  assign state_o  = r_state;
  assign busy     = (r_state == ST_VEND) || (r_state == ST_CHANGE) ||
                    (r_state == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_coin_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_vend_ctrl
// Description : Directed self-checking bench for coin_vend_ctrl. Expected
//               credit values and hopper coin codes are queued as stimulus
//               is applied and compared by a monitor when the DUT shows them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_vend_ctrl;

  localparam int unsigned T_PRICE = 250;
  localparam int unsigned T_HOLD  = 8;
  localparam int unsigned T_TMO   = 20;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_VEND    = 3'd2;
  localparam logic [2:0] S_CHANGE  = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r50 = 1'b0, r100 = 1'b0, r200 = 1'b0, cancel = 1'b0;
  logic        cafe_ack = 1'b0, coin_ack = 1'b0;
  logic        cafe_req, coin_req, reject, busy;
  logic [1:0]  coin_sel;
  logic [11:0] credit_o;
  logic [2:0]  state_o;

  coin_vend_ctrl #(
    .CLK_FREQ       (1000),
    .PRICE          (T_PRICE),
    .HOLD_CYCLES    (T_HOLD),
    .TIMEOUT_CYCLES (T_TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .r50      (r50),
    .r100     (r100),
    .r200     (r200),
    .cancel   (cancel),
    .cafe_ack (cafe_ack),
    .coin_ack (coin_ack),
    .cafe_req (cafe_req),
    .coin_req (coin_req),
    .coin_sel (coin_sel),
    .reject   (reject),
    .credit_o (credit_o),
    .state_o  (state_o),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_credit_q[$];
  logic [1:0]  exp_coin_q[$];
  int          reject_cnt   = 0;
  int          cafe_req_cnt = 0;
  int          coin_req_cnt = 0;
  logic        mon_en       = 1'b0;
  logic [11:0] prev_credit  = 12'd0;
  logic        prev_coin    = 1'b0;
  logic        prev_cafe    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every credit change and every new hopper request is
  // matched against the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (credit_o !== prev_credit) begin
        if (exp_credit_q.size() == 0) check("credit_unexpected", 32'(credit_o), 32'(prev_credit));
        else                          check("credit_seq", 32'(credit_o), 32'(exp_credit_q.pop_front()));
      end
      if (coin_req && !prev_coin) begin
        coin_req_cnt++;
        if (exp_coin_q.size() == 0) check("coin_unexpected", 32'(coin_sel), 32'd0);
        else                        check("coin_sel_seq", 32'(coin_sel), 32'(exp_coin_q.pop_front()));
      end
      if (cafe_req && !prev_cafe) cafe_req_cnt++;
      if (reject) reject_cnt++;
    end
    prev_credit = credit_o;
    prev_coin   = coin_req;
    prev_cafe   = cafe_req;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      50:      r50 = 1'b1;
      100:     r100 = 1'b1;
      200:     r200 = 1'b1;
      default: cancel = 1'b1;
    endcase
    tick();
    r50 = 1'b0; r100 = 1'b0; r200 = 1'b0; cancel = 1'b0;
    tick();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state_o !== s && n < budget) begin tick(); n++; end
    check(tag, 32'(state_o), 32'(s));
  endtask

  task automatic ack_cafe(input string tag);
    int n = 0;
    while (cafe_req !== 1'b1 && n < 50) begin tick(); n++; end
    check(tag, 32'(cafe_req), 32'd1);
    cafe_ack = 1'b1;
    tick();
    cafe_ack = 1'b0;
    check({tag, "_drop"}, 32'(cafe_req), 32'd0);
  endtask

  task automatic ack_coin(input string tag);
    int n = 0;
    while (coin_req !== 1'b1 && n < 50) begin tick(); n++; end
    check(tag, 32'(coin_req), 32'd1);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    check({tag, "_drop"}, 32'(coin_req), 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base_rej;
    int base_cafe;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_state",    32'(state_o),  32'(S_IDLE));
    check("rst_credit",   32'(credit_o), 32'd0);
    check("rst_cafe_req", 32'(cafe_req), 32'd0);
    check("rst_coin_req", 32'(coin_req), 32'd0);
    check("rst_coin_sel", 32'(coin_sel), 32'd0);
    check("rst_reject",   32'(reject),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // 1: exact price, no change, full hold period
    exp_credit_q.push_back(12'd200);
    exp_credit_q.push_back(12'd250);
    exp_credit_q.push_back(12'd0);
    press(200);
    press(50);
    wait_state(S_VEND, 10, "t1_vend");
    check("t1_busy", 32'(busy), 32'd1);
    ack_cafe("t1_cafe");
    check("t1_hold", 32'(state_o), 32'(S_HOLD));
    n = 0;
    while (state_o === S_HOLD && n < 100) begin tick(); n++; end
    check("t1_hold_len", 32'(n), 32'(T_HOLD));
    check("t1_idle", 32'(state_o), 32'(S_IDLE));
    check("t1_no_coin", 32'(coin_req_cnt), 32'd0);
    check("t1_no_reject", 32'(reject_cnt), 32'd0);

    // 2: 400 credit, change 150 = 100 + 50
    exp_credit_q.push_back(12'd200);
    exp_credit_q.push_back(12'd400);
    exp_credit_q.push_back(12'd0);
    exp_coin_q.push_back(2'b10);
    exp_coin_q.push_back(2'b01);
    press(200);
    press(200);
    wait_state(S_VEND, 10, "t2_vend");
    ack_cafe("t2_cafe");
    check("t2_change", 32'(state_o), 32'(S_CHANGE));
    ack_coin("t2_coin100");
    ack_coin("t2_coin50");
    wait_state(S_HOLD, 10, "t2_hold");
    wait_state(S_IDLE, 20, "t2_idle");
    check("t2_coins", 32'(coin_req_cnt), 32'd2);

    // 3: simultaneous inserts served 50, 100, 200 in order
    base_rej = reject_cnt;
    exp_credit_q.push_back(12'd50);
    exp_credit_q.push_back(12'd150);
    exp_credit_q.push_back(12'd350);
    exp_credit_q.push_back(12'd0);
    exp_coin_q.push_back(2'b10);
    r50 = 1'b1; r100 = 1'b1; r200 = 1'b1;
    tick();
    r50 = 1'b0; r100 = 1'b0; r200 = 1'b0;
    wait_state(S_VEND, 10, "t3_vend");
    ack_cafe("t3_cafe");
    ack_coin("t3_coin100");
    wait_state(S_HOLD, 10, "t3_hold");
    check("t3_no_reject", 32'(reject_cnt), 32'(base_rej));
    wait_state(S_IDLE, 20, "t3_idle");

    // 4: cancel refund, dispenser never asked
    base_cafe = cafe_req_cnt;
    exp_credit_q.push_back(12'd100);
    exp_credit_q.push_back(12'd0);
    exp_coin_q.push_back(2'b10);
    press(100);
    check("t4_collect", 32'(state_o), 32'(S_COLLECT));
    press(1);
    check("t4_change", 32'(state_o), 32'(S_CHANGE));
    ack_coin("t4_coin100");
    wait_state(S_HOLD, 10, "t4_hold");
    check("t4_no_cafe", 32'(cafe_req_cnt), 32'(base_cafe));
    wait_state(S_IDLE, 20, "t4_idle");

    // 5: inactivity timeout refund; insert during CHANGE is rejected
    base_rej = reject_cnt;
    exp_credit_q.push_back(12'd50);
    exp_credit_q.push_back(12'd0);
    exp_coin_q.push_back(2'b01);
    press(50);
    n = 0;
    while (state_o === S_COLLECT && n < 100) begin tick(); n++; end
    check("t5_timeout_len", 32'(n), 32'(T_TMO));
    check("t5_change", 32'(state_o), 32'(S_CHANGE));
    press(100);
    ack_coin("t5_coin50");
    check("t5_reject", 32'(reject_cnt), 32'(base_rej + 1));
    check("t5_credit", 32'(credit_o), 32'd0);
    wait_state(S_HOLD, 10, "t5_hold");
    wait_state(S_IDLE, 20, "t5_idle");

    // 6: reset in the middle of a hopper request
    exp_credit_q.push_back(12'd100);
    exp_credit_q.push_back(12'd0);
    exp_coin_q.push_back(2'b10);
    press(100);
    press(1);
    n = 0;
    while (coin_req !== 1'b1 && n < 20) begin tick(); n++; end
    check("t6_coin_req", 32'(coin_req), 32'd1);
    rst = 1'b1;
    tick();
    check("t6_cafe_req", 32'(cafe_req), 32'd0);
    check("t6_coin_req0", 32'(coin_req), 32'd0);
    check("t6_coin_sel", 32'(coin_sel), 32'd0);
    check("t6_reject", 32'(reject), 32'd0);
    check("t6_credit", 32'(credit_o), 32'd0);
    check("t6_state", 32'(state_o), 32'(S_IDLE));
    check("t6_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    tick(); tick();
    check("t6_ack_ignored_state", 32'(state_o), 32'(S_IDLE));
    check("t6_ack_ignored_req", 32'(coin_req), 32'd0);

    check("credit_q_empty", 32'(exp_credit_q.size()), 32'd0);
    check("coin_q_empty", 32'(exp_coin_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coin_vend_ctrl.md
Name: coin_vend_ctrl

Overview:
Vending controller that fronts the coffee machine datapath. It takes raw coin-button levels, edge-detects them and arbitrates simultaneous inserts into a credit accumulator. When credit reaches PRICE it sequences a req/ack handshake with the cup dispenser, then returns change one coin at a time through a hopper handshake. It also handles cancel/timeout refunds and a post-vend hold.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz.
PRICE, 250, product price in cents; must be a multiple of 50 and no more than 2000.
HOLD_CYCLES, CLK_FREQ*4, cycles spent in HOLD after vend or refund.
TIMEOUT_CYCLES, CLK_FREQ*30, idle cycles in COLLECT before an automatic refund.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
r50  in  1  coin-50 button level (already synchronised)
r100  in  1  coin-100 button level
r200  in  1  coin-200 button level
cancel  in  1  refund request level; acted on at its rising edge
cafe_ack  in  1  dispenser done
coin_ack  in  1  hopper ejected the selected coin
cafe_req  out  1  dispense-coffee request
coin_req  out  1  eject-coin request
coin_sel  out  2  01=50, 10=100, 11=200, 00=none
reject  out  1  1-cycle pulse: an inserted coin was not accepted
credit_o  out  12  current credit in cents
state_o  out  3  FSM state encoding
busy  out  1  high in VEND, CHANGE or HOLD

Behaviour:
- Reset values: all outputs 0, credit 0, pending bits 0, timers 0, state IDLE. Reset mid-handshake abandons the transaction and loses the credit.
- Edge detect: per coin input, a registered previous level; a rising edge is prev=0 and now=1. A held button counts once.
- Pending register, 3 bits, one per denomination:
  - An edge in IDLE or COLLECT sets that denomination's bit.
  - An edge whose bit is already set pulses reject.
  - An edge in VEND, CHANGE or HOLD pulses reject.
  - Simultaneous edges on different denominations all set their bits, with no reject.
- Arbitration: in IDLE or COLLECT, at most one pending bit is served per cycle, fixed priority 50 > 100 > 200. Serving clears the bit and adds the value to credit. Credit is registered, so the add is visible on credit_o the next cycle.
- States and encodings:
  - IDLE=0: the first coin served goes to COLLECT.
  - COLLECT=1:
    - Timer clears on each served coin and increments otherwise.
    - If credit >= PRICE, go to VEND. This check has priority over serving. Still-set pending bits are cleared and reject pulses once.
    - Else, if a cancel edge arrives or the timer equals TIMEOUT_CYCLES-1, go to CHANGE with change = credit (refund) and refund flag = 1.
  - VEND=2:
    - cafe_req is a registered output, high from the first cycle in VEND.
    - On sampling cafe_ack=1: cafe_req drops the next cycle, change = credit - PRICE, credit = 0.
    - Then go to CHANGE if change != 0, else HOLD.
  - CHANGE=3:
    - Greedy selection: 200 if change >= 200, else 100 if >= 100, else 50.
    - coin_req=1 with coin_sel stable until coin_ack is sampled high. Then deassert, subtract the coin value, and keep coin_req low for at least 1 cycle before the next request.
    - coin_ack while coin_req=0 is ignored.
    - When change reaches 0, go to HOLD.
    - On a refund, credit is cleared on entry to CHANGE.
  - HOLD=4: count HOLD_CYCLES, then go to IDLE with the hold counter cleared. busy is high.
- Widths:
  - credit and change are 12-bit unsigned. The maximum credit is PRICE-50+200.
  - Timers are 32-bit.
  - Unused encodings 5-7 go to IDLE the next cycle.
- cancel in VEND, CHANGE or HOLD is ignored. cancel in IDLE with zero credit is ignored.
- Handshake peers may ack in the same cycle req rises. Latency from ack to the next req is 2 cycles.

Decomposition:
- Shared package vend_pkg holds:
  - state encodings IDLE..HOLD;
  - coin_sel codes COIN_NONE/50/100/200;
  - the coin value constants 50/100/200.
- One natural sub-module: coin_edge_arb, covering edge detect, pending bits, priority serve, and the reject pulse. Its outputs are serve_valid and serve_value[7:0].

Test Plan:
1. r200 then r50, PRICE=250 -> credit 200, then 250; VEND; cafe_ack -> change 0; HOLD for HOLD_CYCLES; back to IDLE with no coin_req.
2. r200 then r200 -> credit 400; after cafe_ack, hopper sequence coin_sel=10 (100), then 01 (50), with change ending at 0.
3. r50, r100 and r200 rising in the same cycle from IDLE -> served over 3 cycles as 50, 150, 350; vend; change 100 as one coin_sel=10; no reject.
4. r100, then cancel edge -> CHANGE refund of one coin_sel=10, then HOLD; cafe_req never asserted.
5. r50, then no input for TIMEOUT_CYCLES (reduced params) -> refund of a coin_sel=01; r100 pressed during CHANGE -> one reject pulse; credit unchanged.
6. rst asserted while coin_req=1 in CHANGE -> next cycle all outputs 0, state_o=0, credit_o=0; a later coin_ack is ignored.
